// File: rtl/spi_flash_read_arbiter_pkg.sv
// Shared definitions for the SPI flash block-read arbiter.
//   FlashAddrW : width of a flash byte address
//   state_e    : arbiter FSM encoding (IDLE / ISSUE / WAIT, 2-bit)
//   clog2      : ceiling log2, usable in localparam expressions
package spi_flash_read_arbiter_pkg;

    localparam int unsigned FlashAddrW = 24;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < longint'(v)) begin
            x = x * 2;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_flash_read_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   pend : per-requester pending bits
//   last : index of the most recently granted requester
//   sel  : first pending index found searching last+1, last+2, ... (mod N_REQ)
//   any  : at least one requester is pending (sel is valid)
module spi_flash_read_arbiter_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned SelW  = 2
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [SelW-1:0]  last,
    output logic [SelW-1:0]  sel,
    output logic             any
);

    always_comb begin
        int unsigned idx;
        sel = '0;
        any = 1'b0;
        idx = 0;
        // Offset N_REQ wraps back to last itself, so it is considered last.
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(last) + i) % N_REQ;
            if (!any && pend[idx]) begin
                sel = SelW'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_flash_read_arbiter.sv
// Shares one spi_flash_ctrl block-read engine between N_REQ requesters.
// Each requester posts a one-cycle strobe with a flash address; one read per requester is
// queued, granted round-robin, issued to the controller and reported as done or timed out.
// All outputs are registered.
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_stb/i_req_addr  per-slot read strobe and packed 24-bit address (slot k at [24k+:24])
//   o_grant               one-hot owner of controller/BRAM during ISSUE and WAIT
//   o_done/o_timeout      one-cycle completion / abandonment pulse for the owning slot
//   o_overrun             one-cycle pulse: strobe dropped because the slot was already pending
//   o_busy                FSM not idle
//   o_ctrl_read_*         read strobe/address to the controller; i_ctrl_read_done_stb back
module spi_flash_read_arbiter
    import spi_flash_read_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned BLOCK_SIZE     = 512,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [N_REQ-1:0]            i_req_stb,
    input  logic [FlashAddrW*N_REQ-1:0] i_req_addr,
    output logic [N_REQ-1:0]            o_grant,
    output logic [N_REQ-1:0]            o_done,
    output logic [N_REQ-1:0]            o_timeout,
    output logic [N_REQ-1:0]            o_overrun,
    output logic                        o_busy,
    output logic [FlashAddrW-1:0]       o_ctrl_read_addr,
    output logic                        o_ctrl_read_stb,
    input  logic                        i_ctrl_read_done_stb
);

    localparam int unsigned SelW   = clog2(N_REQ);
    localparam int unsigned TimerW = clog2(TIMEOUT_CYCLES);
    localparam logic [FlashAddrW-1:0] AddrMask = ~(FlashAddrW'(BLOCK_SIZE - 1));

    state_e                 state_q, state_d;
    logic [N_REQ-1:0]       pend_q, pend_d;
    logic [SelW-1:0]        last_q, last_d;
    logic [SelW-1:0]        sel_q, sel_d;
    logic [TimerW-1:0]      timer_q, timer_d;
    logic [FlashAddrW-1:0]  addr_q [N_REQ];

    logic [SelW-1:0]        pick_sel;
    logic                   pick_any;
    logic                   done_evt, timeout_evt;
    logic [N_REQ-1:0]       sel_oh_q, sel_oh_d, clr, accept;

    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [N_REQ-1:0]       done_q, done_d;
    logic [N_REQ-1:0]       timeout_q, timeout_d;
    logic [N_REQ-1:0]       overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic [FlashAddrW-1:0]  ctrl_addr_q, ctrl_addr_d;
    logic                   ctrl_stb_q, ctrl_stb_d;

    spi_flash_read_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .SelW  (SelW)
    ) u_pick (
        .pend (pend_q),
        .last (last_q),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    assign sel_oh_q = N_REQ'(1) << sel_q;
    assign sel_oh_d = N_REQ'(1) << sel_d;

    // Done has priority over a coincident timeout.
    assign done_evt    = (state_q == StWait) && i_ctrl_read_done_stb;
    assign timeout_evt = (state_q == StWait) && !i_ctrl_read_done_stb &&
                         (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

    // A strobe landing on the slot being cleared this cycle is accepted, not dropped.
    assign clr    = (done_evt || timeout_evt) ? sel_oh_q : '0;
    assign accept = i_req_stb & (~pend_q | clr);
    assign pend_d = (pend_q & ~clr) | i_req_stb;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    sel_d   = pick_sel;
                    last_d  = pick_sel;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (done_evt || timeout_evt) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: computed from the next state so the registered outputs line up with it.
    always_comb begin
        grant_d     = (state_d != StIdle) ? sel_oh_d : '0;
        busy_d      = (state_d != StIdle);
        ctrl_stb_d  = (state_d == StIssue);
        ctrl_addr_d = (state_d != StIdle) ? addr_q[sel_d] : '0;
        done_d      = done_evt ? sel_oh_q : '0;
        timeout_d   = timeout_evt ? sel_oh_q : '0;
        overrun_d   = i_req_stb & pend_q & ~clr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q      <= '0;
            last_q      <= SelW'(N_REQ - 1);
            sel_q       <= '0;
            timer_q     <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            timeout_q   <= '0;
            overrun_q   <= '0;
            busy_q      <= 1'b0;
            ctrl_addr_q <= '0;
            ctrl_stb_q  <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            ctrl_addr_q <= ctrl_addr_d;
            ctrl_stb_q  <= ctrl_stb_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                addr_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (accept[k]) begin
                    addr_q[k] <= i_req_addr[k*FlashAddrW +: FlashAddrW] & AddrMask;
                end
            end
        end
    end

    assign o_grant          = grant_q;
    assign o_done           = done_q;
    assign o_timeout        = timeout_q;
    assign o_overrun        = overrun_q;
    assign o_busy           = busy_q;
    assign o_ctrl_read_addr = ctrl_addr_q;
    assign o_ctrl_read_stb  = ctrl_stb_q;

endmodule
